// File: rtl/adc_pkg.sv
// Shared types and helpers for the LTC2308 scan controller: FSM states,
// ADC geometry, SDI configuration word and round-robin channel search.
package adc_pkg;

   localparam int ADC_BITS = 12;
   localparam int NUM_CH   = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_SHIFT,
      ST_CONV
   } state_e;

   // {S/D, O/S, S1, S0, UNI, SLP, 6'b0}: single-ended, unipolar, awake
   function automatic logic [ADC_BITS-1:0] adc_cfg_word(input logic [2:0] ch);
      return {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0, 6'b000000};
   endfunction

   // Descending scan so the nearest enabled channel after 'last' wins;
   // offset NUM_CH wraps back onto 'last' itself for a single-bit mask.
   function automatic logic [2:0] next_ch(input logic [NUM_CH-1:0] mask,
                                          input logic [2:0]        last);
      logic [2:0] c;
      next_ch = last;
      for (int i = NUM_CH; i >= 1; i--) begin
         c = last + 3'(i);
         if (mask[c]) next_ch = c;
      end
   endfunction

endpackage

// File: rtl/adc_spi_shifter.sv
// 12-bit full-duplex SPI shift engine: SCK idles low, each bit is CLK_DIV
// cycles low then CLK_DIV cycles high; SDI moves on the falling edge.
module adc_spi_shifter
   import adc_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [ADC_BITS-1:0] tx_word,
   input  logic                sdo,
   output logic                sck,
   output logic                sdi,
   output logic                done,
   output logic [ADC_BITS-1:0] rx_word
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic                active_q, active_d;
   logic                sck_q, sck_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [3:0]          bit_q, bit_d;
   logic [ADC_BITS-1:0] tx_q, tx_d;
   logic [ADC_BITS-1:0] rx_q, rx_d;
   logic                half_end;

   assign half_end = active_q && (div_q == DIV_W'(CLK_DIV - 1));
   assign done     = half_end && sck_q && (bit_q == 4'(ADC_BITS - 1));

   always_comb begin
      active_d = active_q;
      sck_d    = sck_q;
      div_d    = div_q;
      bit_d    = bit_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      if (start) begin
         active_d = 1'b1;
         sck_d    = 1'b0;
         div_d    = '0;
         bit_d    = '0;
         tx_d     = tx_word;
      end else if (active_q) begin
         if (half_end) begin
            div_d = '0;
            sck_d = !sck_q;
            if (sck_q) begin
               bit_d = bit_q + 4'd1;
               tx_d  = {tx_q[ADC_BITS-2:0], 1'b0};
               if (done) active_d = 1'b0;
            end else begin
               rx_d = {rx_q[ADC_BITS-2:0], sdo};
            end
         end else begin
            div_d = div_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active_q <= 1'b0;
         sck_q    <= 1'b0;
         div_q    <= '0;
         bit_q    <= '0;
      end else begin
         active_q <= active_d;
         sck_q    <= sck_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
      end
   end

   always_ff @(posedge clk) begin
      tx_q <= tx_d;
      rx_q <= rx_d;
   end

   assign sck     = sck_q;
   assign sdi     = active_q & tx_q[ADC_BITS-1];
   assign rx_word = rx_q;

endmodule

// File: rtl/adc_scan_ctrl.sv
// Round-robin LTC2308 scan controller. The ADC returns each result one frame
// late; conv_pending/conv_ch track which channel the next frame's data is for.
module adc_scan_ctrl
   import adc_pkg::*;
#(
   parameter int CLK_DIV     = 2,
   parameter int CONV_CYCLES = 80
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run_i,
   input  logic [NUM_CH-1:0]   ch_mask_i,
   output logic                busy_o,
   output logic                res_valid_o,
   input  logic                res_ready_i,
   output logic [2:0]          res_ch_o,
   output logic [ADC_BITS-1:0] res_data_o,
   output logic                adc_convst_o,
   output logic                adc_sck_o,
   output logic                adc_sdi_o,
   input  logic                adc_sdo_i
);

   localparam int CNT_W = $clog2(CONV_CYCLES + 1);

   state_e              state_q, state_d;
   logic                conv_pending_q, conv_pending_d;
   logic                rd_only_q, rd_only_d;
   logic [2:0]          last_ch_q, last_ch_d;
   logic [2:0]          cfg_ch_q, cfg_ch_d;
   logic [2:0]          conv_ch_q, conv_ch_d;
   logic                res_valid_q, res_valid_d;
   logic [2:0]          res_ch_q, res_ch_d;
   logic [ADC_BITS-1:0] res_data_q, res_data_d;
   logic                convst_q, convst_d;
   logic                busy_q, busy_d;
   logic [CNT_W-1:0]    conv_cnt_q, conv_cnt_d;

   logic                sh_start, sh_done;
   logic [ADC_BITS-1:0] sh_tx, sh_rx;
   logic                out_free, stop_req;
   logic [2:0]          sel_ch;

   always_comb begin
      state_d        = state_q;
      conv_pending_d = conv_pending_q;
      rd_only_d      = rd_only_q;
      last_ch_d      = last_ch_q;
      cfg_ch_d       = cfg_ch_q;
      conv_ch_d      = conv_ch_q;
      res_valid_d    = res_valid_q;
      res_ch_d       = res_ch_q;
      res_data_d     = res_data_q;
      convst_d       = convst_q;
      conv_cnt_d     = conv_cnt_q;
      sh_start       = 1'b0;
      sh_tx          = '0;
      out_free       = !res_valid_q || res_ready_i;
      stop_req       = !run_i || (ch_mask_i == '0);
      sel_ch         = next_ch(ch_mask_i, last_ch_q);

      if (res_ready_i) res_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            conv_pending_d = 1'b0;
            last_ch_d      = 3'd7;
            if (!stop_req) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (out_free) begin
               if (stop_req) begin
                  // A conversion already in the ADC still has to be read out
                  if (conv_pending_q) begin
                     sh_start  = 1'b1;
                     rd_only_d = 1'b1;
                     state_d   = ST_SHIFT;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  sh_start  = 1'b1;
                  sh_tx     = adc_cfg_word(sel_ch);
                  cfg_ch_d  = sel_ch;
                  last_ch_d = sel_ch;
                  rd_only_d = 1'b0;
                  state_d   = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            if (sh_done) begin
               if (conv_pending_q) begin
                  res_valid_d = 1'b1;
                  res_ch_d    = conv_ch_q;
                  res_data_d  = sh_rx;
               end
               if (rd_only_q) begin
                  conv_pending_d = 1'b0;
                  state_d        = ST_IDLE;
               end else begin
                  conv_ch_d      = cfg_ch_q;
                  conv_pending_d = 1'b1;
                  convst_d       = 1'b1;
                  conv_cnt_d     = '0;
                  state_d        = ST_CONV;
               end
            end
         end
         ST_CONV: begin
            if (conv_cnt_q == CNT_W'(CONV_CYCLES - 1)) begin
               convst_d = 1'b0;
               state_d  = ST_WAIT;
            end else begin
               conv_cnt_d = conv_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         conv_pending_q <= 1'b0;
         rd_only_q      <= 1'b0;
         last_ch_q      <= 3'd7;
         cfg_ch_q       <= '0;
         conv_ch_q      <= '0;
         res_valid_q    <= 1'b0;
         res_ch_q       <= '0;
         res_data_q     <= '0;
         convst_q       <= 1'b0;
         busy_q         <= 1'b0;
         conv_cnt_q     <= '0;
      end else begin
         state_q        <= state_d;
         conv_pending_q <= conv_pending_d;
         rd_only_q      <= rd_only_d;
         last_ch_q      <= last_ch_d;
         cfg_ch_q       <= cfg_ch_d;
         conv_ch_q      <= conv_ch_d;
         res_valid_q    <= res_valid_d;
         res_ch_q       <= res_ch_d;
         res_data_q     <= res_data_d;
         convst_q       <= convst_d;
         busy_q         <= busy_d;
         conv_cnt_q     <= conv_cnt_d;
      end
   end

   adc_spi_shifter #(
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .clk     (clk),
      .rst     (rst),
      .start   (sh_start),
      .tx_word (sh_tx),
      .sdo     (adc_sdo_i),
      .sck     (adc_sck_o),
      .sdi     (adc_sdi_o),
      .done    (sh_done),
      .rx_word (sh_rx)
   );

   assign busy_o       = busy_q;
   assign res_valid_o  = res_valid_q;
   assign res_ch_o     = res_ch_q;
   assign res_data_o   = res_data_q;
   assign adc_convst_o = convst_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Bench for adc_scan_ctrl: LTC2308 pin model feeding a result scoreboard,
// table-driven scan scenarios and hand-written stall/stop/reset sequences.
module tb_adc_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst, run_i, res_ready_i, adc_sdo;
   logic [7:0]  ch_mask_i;
   logic        busy_o, res_valid_o, adc_convst_o, adc_sck_o, adc_sdi_o;
   logic [2:0]  res_ch_o;
   logic [11:0] res_data_o;

   always #5 clk = ~clk;

   adc_scan_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .run_i        (run_i),
      .ch_mask_i    (ch_mask_i),
      .busy_o       (busy_o),
      .res_valid_o  (res_valid_o),
      .res_ready_i  (res_ready_i),
      .res_ch_o     (res_ch_o),
      .res_data_o   (res_data_o),
      .adc_convst_o (adc_convst_o),
      .adc_sck_o    (adc_sck_o),
      .adc_sdi_o    (adc_sdi_o),
      .adc_sdo_i    (adc_sdo)
   );

   typedef struct packed {
      logic [7:0]  mask;
      logic [2:0]  n;
      logic [11:0] seq;     // element i at [3*i +: 3]
      logic        chk_cfg;
      logic [11:0] cfg;
   } vec_t;

   vec_t        vecs [5];
   int          n_cmp = 0, n_err = 0, cyc = 0;
   int          nbits = 0, kbit = 0, overlap = 0, n_conv = 0;
   logic [11:0] sr = '0, last_word = '0, conv_cfg = '0, adc_res = '0;
   logic [2:0]  ch_m;
   logic        prev_valid = 1'b0, prev_sck = 1'b0, prev_convst = 1'b0;
   logic [14:0] sb [$];
   logic [2:0]  got_ch [$];
   logic [11:0] got_data [$];
   int          rise_cyc [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail_timeout(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timed out at cycle %0d, awaited event never seen", name, cyc);
   endtask

   // One clock: handshake inputs are sampled before the edge, pins after it.
   task automatic tick();
      logic        acc, stall, rst_pre;
      logic [2:0]  a_ch;
      logic [11:0] a_data;
      logic [14:0] e;
      acc     = res_valid_o && res_ready_i;
      stall   = res_valid_o && !res_ready_i;
      a_ch    = res_ch_o;
      a_data  = res_data_o;
      rst_pre = rst;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (rst_pre) begin
         sb.delete();
         nbits       = 0;
         kbit        = 0;
         prev_valid  = 1'b0;
         prev_sck    = adc_sck_o;
         prev_convst = adc_convst_o;
         adc_sdo     = 1'b0;
         return;
      end
      if (acc) begin
         got_ch.push_back(a_ch);
         got_data.push_back(a_data);
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_underflow: result ch%0d data %0h delivered, no conversion outstanding", a_ch, a_data);
         end else begin
            e = sb.pop_front();
            chk("sb_ch", 32'(a_ch), 32'(e[14:12]));
            chk("sb_data", 32'(a_data), 32'(e[11:0]));
         end
      end
      if (stall) begin
         chk("hold_valid", 32'(res_valid_o), 32'd1);
         chk("hold_ch", 32'(res_ch_o), 32'(a_ch));
         chk("hold_data", 32'(res_data_o), 32'(a_data));
      end
      if (res_valid_o && !prev_valid) rise_cyc.push_back(cyc);
      prev_valid = res_valid_o;
      if (adc_convst_o && adc_sck_o) overlap++;
      if (adc_sck_o && !prev_sck) begin
         sr = {sr[10:0], adc_sdi_o};
         nbits++;
         if (nbits % 12 == 0) last_word = sr;
      end
      if (!adc_sck_o && prev_sck) kbit++;
      if (adc_convst_o && !prev_convst) begin
         chk("sck_per_frame", 32'(nbits), 32'd12);
         conv_cfg = last_word;
         ch_m     = {last_word[9], last_word[8], last_word[10]};
         adc_res  = 12'hA00 + {9'd0, ch_m};
         sb.push_back({ch_m, adc_res});
         n_conv++;
         nbits = 0;
         kbit  = 0;
      end
      if (!busy_o) nbits = 0;
      adc_sdo     = (kbit < 12) ? adc_res[11 - kbit] : 1'b0;
      prev_sck    = adc_sck_o;
      prev_convst = adc_convst_o;
   endtask

   task automatic wait_got(input int target, input int budget, input string name);
      int i = 0;
      while (got_ch.size() < target && i < budget) begin
         tick();
         i++;
      end
      if (got_ch.size() < target) fail_timeout(name);
   endtask

   task automatic stop_and_drain(input string name);
      int i = 0;
      run_i = 1'b0;
      while (busy_o && i < 600) begin
         tick();
         i++;
      end
      if (busy_o) fail_timeout({name, "_idle"});
      repeat (5) tick();
      chk({name, "_sb_drained"}, 32'(sb.size()), 32'd0);
   endtask

   task automatic check_seq(input string name, input int base, input int n, input logic [11:0] seq);
      logic [2:0] c;
      for (int j = 0; j < n; j++) begin
         if (got_ch.size() > base + j) begin
            c = seq[3*j +: 3];
            chk($sformatf("%s_ch%0d", name, j), 32'(got_ch[base + j]), 32'(c));
            chk($sformatf("%s_data%0d", name, j), 32'(got_data[base + j]), 32'h0A00 + 32'(c));
         end
      end
   endtask

   task automatic run_scan(input vec_t v, input int r);
      int    bg, br, t0;
      string nm;
      nm        = $sformatf("row%0d", r);
      bg        = got_ch.size();
      br        = rise_cyc.size();
      ch_mask_i = v.mask;
      run_i     = 1'b1;
      t0        = cyc;
      wait_got(bg + int'(v.n), 1200, {nm, "_results"});
      if (rise_cyc.size() >= br + int'(v.n)) begin
         chk({nm, "_first_latency"}, 32'(rise_cyc[br] - t0), 32'd179);
         for (int j = 1; j < int'(v.n); j++)
            chk($sformatf("%s_spacing%0d", nm, j), 32'(rise_cyc[br + j] - rise_cyc[br + j - 1]), 32'd129);
      end
      check_seq(nm, bg, int'(v.n), v.seq);
      if (v.chk_cfg) chk({nm, "_cfg_word"}, 32'(conv_cfg), 32'(v.cfg));
      stop_and_drain(nm);
   endtask

   initial begin
      int bg, br, bc, t0, viol, i;

      vecs[0] = '{mask: 8'h05, n: 3'd4, seq: {3'd2, 3'd0, 3'd2, 3'd0}, chk_cfg: 1'b0, cfg: 12'h000};
      vecs[1] = '{mask: 8'h02, n: 3'd3, seq: {3'd0, 3'd1, 3'd1, 3'd1}, chk_cfg: 1'b1, cfg: 12'hC80};
      vecs[2] = '{mask: 8'h81, n: 3'd3, seq: {3'd0, 3'd0, 3'd7, 3'd0}, chk_cfg: 1'b0, cfg: 12'h000};
      vecs[3] = '{mask: 8'h48, n: 3'd3, seq: {3'd0, 3'd3, 3'd6, 3'd3}, chk_cfg: 1'b0, cfg: 12'h000};
      vecs[4] = '{mask: 8'h80, n: 3'd3, seq: {3'd0, 3'd7, 3'd7, 3'd7}, chk_cfg: 1'b1, cfg: 12'hF80};

      rst         = 1'b1;
      run_i       = 1'b0;
      res_ready_i = 1'b1;
      ch_mask_i   = 8'h00;
      adc_sdo     = 1'b0;
      repeat (3) tick();
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_valid", 32'(res_valid_o), 32'd0);
      chk("rst_ch", 32'(res_ch_o), 32'd0);
      chk("rst_data", 32'(res_data_o), 32'd0);
      chk("rst_convst", 32'(adc_convst_o), 32'd0);
      chk("rst_sck", 32'(adc_sck_o), 32'd0);
      chk("rst_sdi", 32'(adc_sdi_o), 32'd0);
      rst = 1'b0;
      tick();

      for (int r = 0; r < 5; r++) run_scan(vecs[r], r);

      // Backpressure: hold the first result for 500 cycles
      ch_mask_i   = 8'h05;
      res_ready_i = 1'b0;
      run_i       = 1'b1;
      i = 0;
      while (!res_valid_o && i < 400) begin
         tick();
         i++;
      end
      if (!res_valid_o) fail_timeout("bp_first_valid");
      chk("bp_held_ch", 32'(res_ch_o), 32'd0);
      chk("bp_held_data", 32'(res_data_o), 32'h0A00);
      bg   = got_ch.size();
      viol = 0;
      for (int t = 0; t < 500; t++) begin
         tick();
         if (t >= 100 && (adc_convst_o || adc_sck_o || !busy_o)) viol++;
      end
      chk("bp_wait_pins", 32'(viol), 32'd0);
      chk("bp_still_valid", 32'(res_valid_o), 32'd1);
      res_ready_i = 1'b1;
      wait_got(bg + 4, 800, "bp_release");
      check_seq("bp", bg, 4, {3'd2, 3'd0, 3'd2, 3'd0});
      stop_and_drain("bp");

      // Stop during CONV on CH3
      ch_mask_i = 8'h08;
      run_i     = 1'b1;
      bc = n_conv;
      i  = 0;
      while (n_conv == bc && i < 300) begin
         tick();
         i++;
      end
      if (n_conv == bc) fail_timeout("stop_convst_rise");
      repeat (10) tick();
      run_i = 1'b0;
      bg = got_ch.size();
      bc = n_conv;
      i  = 0;
      while (busy_o && i < 600) begin
         tick();
         i++;
      end
      if (busy_o) fail_timeout("stop_idle");
      repeat (200) tick();
      chk("stop_result_count", 32'(got_ch.size() - bg), 32'd1);
      if (got_ch.size() > bg) begin
         chk("stop_ch", 32'(got_ch[bg]), 32'd3);
         chk("stop_data", 32'(got_data[bg]), 32'h0A03);
      end
      chk("stop_no_convst", 32'(n_conv - bc), 32'd0);
      chk("stop_busy", 32'(busy_o), 32'd0);
      chk("stop_rdonly_sdi", 32'(last_word), 32'd0);
      chk("stop_sb_drained", 32'(sb.size()), 32'd0);

      // Reset mid-SHIFT, then restart with a discard frame
      ch_mask_i = 8'h81;
      run_i     = 1'b1;
      bg = got_ch.size();
      wait_got(bg + 1, 400, "rs_first");
      i = 0;
      while (!adc_sck_o && i < 300) begin
         tick();
         i++;
      end
      if (!adc_sck_o) fail_timeout("rs_sck");
      rst = 1'b1;
      tick();
      chk("rs_busy", 32'(busy_o), 32'd0);
      chk("rs_valid", 32'(res_valid_o), 32'd0);
      chk("rs_ch", 32'(res_ch_o), 32'd0);
      chk("rs_data", 32'(res_data_o), 32'd0);
      chk("rs_convst", 32'(adc_convst_o), 32'd0);
      chk("rs_sck", 32'(adc_sck_o), 32'd0);
      chk("rs_sdi", 32'(adc_sdi_o), 32'd0);
      rst = 1'b0;
      t0  = cyc;
      bg  = got_ch.size();
      br  = rise_cyc.size();
      wait_got(bg + 3, 900, "rs_restart");
      if (rise_cyc.size() > br) chk("rs_first_latency", 32'(rise_cyc[br] - t0), 32'd179);
      check_seq("rs", bg, 3, {3'd0, 3'd0, 3'd7, 3'd0});
      stop_and_drain("rs");

      chk("pin_convst_sck_overlap", 32'(overlap), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/adc_scan_ctrl.md
# adc_scan_ctrl

Round-robin scan controller for the board's 8-channel, 12-bit serial ADC (LTC2308: CONVST, SCK, SDI and SDO lines). It sits between the ADC pins and a fabric consumer such as a CPU-subsystem bridge. It cycles through the channels enabled in a mask, sequences conversion and shift frames, and presents each result with its channel number on a valid/ready output. The ADC returns each result one frame late, and the controller hides that pipelining from the consumer.

## Interface
- `CLK_DIV`, default 2: clk cycles per SCK half-period, ≥1 (2 gives 12.5 MHz SCK at 50 MHz).
- `CONV_CYCLES`, default 80: CONVST-high duration in clk cycles, ≥ tCONV (1.6 µs at 50 MHz).

Ports:
- `clk  in  1`: system clock. One clock domain.
- `rst  in  1`: reset, synchronous, active-high.
- `run_i  in  1`: level signal; scanning proceeds while high.
- `ch_mask_i  in  8`: enabled channels, bit n = CHn.
- `busy_o  out  1`: high in any state other than IDLE.
- `res_valid_o  out  1`: a result is held on the output.
- `res_ready_i  in  1`: consumer accepts the result.
- `res_ch_o  out  3`: channel the result belongs to.
- `res_data_o  out  12`: conversion code, unipolar straight binary.
- `adc_convst_o  out  1`: drives the CONVST pin.
- `adc_sck_o  out  1`: SPI clock; idles low.
- `adc_sdi_o  out  1`: configuration word to the ADC.
- `adc_sdo_i  in  1`: result data from the ADC.

## Operation
- **States:** IDLE, WAIT, SHIFT, CONV.
- **IDLE.** On `run_i` high with `ch_mask_i` non-zero, pick the next channel and go to WAIT. `conv_pending` is 0 in IDLE.
- **WAIT.** Proceed to SHIFT only when the output register is free, i.e. `!res_valid_o` or `res_ready_i` is high this cycle.
- **Start of SHIFT:**
  - If `conv_pending` is set and (`run_i` is low or the mask is 0), run a read-only SHIFT. The config is don't-care; drive 0. The frame ends in IDLE.
  - Otherwise latch `cfg_ch` = the next enabled channel strictly after `last_ch`, searching upward with wrap-around 7→0. After reset or IDLE, the search starts at CH0.
- **SHIFT.** Runs 12 SCK periods.
  - SDI carries a 12-bit word, MSB first: {S/D=1, O/S=ch[0], S1=ch[2], S0=ch[1], UNI=1, SLP=0, 6'b0}.
  - SDO is captured into a shift register on each SCK rising edge, MSB first.
  - At frame end, if `conv_pending` is set, load `res_data_o` and set `res_ch_o` = `conv_ch`, then assert `res_valid_o`.
  - After a normal frame: `conv_ch` ← `cfg_ch`, `conv_pending` ← 1, go to CONV.
  - After a read-only frame: `conv_pending` ← 0, go to IDLE.
- **CONV.** `adc_convst_o` is high for exactly `CONV_CYCLES` cycles, then low, and the FSM goes to WAIT.
- **Discarded frame.** The first SHIFT after IDLE has `conv_pending` = 0, so its data is discarded.
- **Mask change mid-scan.** Takes effect at the next SHIFT start. A channel disabled after its conversion started is still reported.
- **Single enabled channel.** That channel is selected repeatedly.
- **`res_valid_o` rules:** it stays high until `res_ready_i`. Data and channel are stable while it is high. On a cycle with accept and a new load together, the new result wins and `res_valid_o` stays high.

## Timing
- **Reset values:** every output is 0, `adc_sck_o` is low, state is IDLE, `conv_pending` = 0, `last_ch` = 7. Reset mid-frame aborts immediately. An in-flight ADC conversion completes harmlessly, and the next frame after reset is a discard frame.
- **SCK bit cell:** each bit is `CLK_DIV` cycles low then `CLK_DIV` cycles high. SDI changes only on the cycle SCK goes low. SDO is sampled on the cycle SCK goes high.
- **SHIFT length:** 24·`CLK_DIV` cycles; `adc_sck_o` is low on entry to and exit from SHIFT.
- **Pin lines outside their active state:**
  - `adc_convst_o` is low throughout SHIFT, WAIT and IDLE.
  - `adc_sck_o` and `adc_sdi_o` are low outside SHIFT.
- **Steady-state frame:** 24·`CLK_DIV` + `CONV_CYCLES` + 1 (WAIT) cycles when unstalled; 129 cycles at the defaults.
- **First result** after `run_i` rises from IDLE (defaults): 1 + 1 + 48 + 80 + 1 + 48 = 179 cycles. `res_valid_o` is high in the cycle after the last SHIFT cycle of the second frame.

## Structure
- **Package `adc_pkg`:**
  - state enum;
  - `ADC_BITS` = 12 and `NUM_CH` = 8;
  - function `adc_cfg_word(ch)` returning the 12-bit SDI word;
  - function `next_ch(mask, last)` implementing the round-robin search.
- **Sub-module `adc_spi_shifter`:** a 12-bit full-duplex shift engine with SCK generation.
  - Inputs: `start`, `tx_word`.
  - Outputs: `done` (1-cycle pulse), `rx_word`.
  - Parameter: `CLK_DIV`.
- **Top level:** the FSM, channel selection and result register.

## Test plan
- **Basic scan:** mask=8'h05, `run_i` held high, `res_ready_i`=1, ADC model returns 12'hA00+channel. Results alternate CH0, CH2, CH0… with matching data. The first result appears at cycle 179 and results are spaced 129 cycles apart.
- **Config word:** mask=8'h02. Decoded SDI word = 12'b1100_1000_0000 (CH1: S/D=1, O/S=1, S1=0, S0=0, UNI=1); SCK count = 12 per frame.
- **Backpressure:** `res_ready_i`=0 for 500 cycles. Exactly one result is held stable, the FSM sits in WAIT with CONVST low, and nothing is lost or duplicated after release.
- **Stop:** drop `run_i` during CONV on CH3. One read-only frame delivers the CH3 result, then IDLE with `busy_o`=0 and no further CONVST pulse.
- **Wrap and reset:** mask=8'h81 shows the sequence CH0, CH7, CH0. Assert `rst` mid-SHIFT: all outputs are 0 next cycle, and the restart begins with a discard frame.
